pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter BALL_SPEED, 2, ball offset step per frame tick on each axis (pixels).
REQ-002 Parameter PADDLE_SPEED, 4, paddle offset step per frame tick (pixels).
REQ-003 Parameter SERVE_FRAMES, 60, frame ticks spent in SERVE before play starts.
REQ-004 Parameter POINT_FRAMES, 90, frame ticks spent in POINT after a score.
REQ-005 Parameter WIN_SCORE, 7, score (1..15) that ends the game.
REQ-006 clk  in  1  single system clock; all state is updated on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 frame_tick  in  1  one-cycle pulse, once per video frame.
REQ-009 start  in  1  level; begins or restarts a game.
REQ-010 btn_L_up, btn_L_dn, btn_R_up, btn_R_dn  in  1 each  paddle controls, level.
REQ-011 ball_detect_edge  in  4  active-low; [0] bottom, [1] right, [2] top, [3] left.
REQ-012 paddle_L_detect_edge, paddle_R_detect_edge  in  4 each  active-low; [0] at bottom, [1] at top; [3:2] ignored.
REQ-013 collision_detect  in  8  active-high; [0] R-paddle x, [2] R-paddle y, [1] L-paddle x, [5] L-paddle y; other bits ignored.
REQ-014 ball_off_x, ball_off_y  out  32  ball offset, modulo-2^32 (negative as two's complement).
REQ-015 paddle_L_off_y, paddle_R_off_y  out  32  paddle y offset, modulo-2^32.
REQ-016 score_L, score_R  out  4  current scores.
REQ-017 game_state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4.
REQ-018 point_pulse  out  1  one-cycle pulse when a point is awarded.

Function
REQ-019 The FSM SHALL advance only on frame_tick, except for IDLE/GAME_OVER -> SERVE, which SHALL occur on the first clk edge with start=1.
REQ-020 All outputs SHALL be registered; a frame_tick sampled at edge N SHALL update its outputs visibly after edge N.
REQ-021 IDLE -> SERVE on start=1; ball offsets, paddle offsets and scores SHALL be cleared, dir_x=right, dir_y=down.
REQ-022 SERVE SHALL count SERVE_FRAMES frame ticks with the ball held at offset 0, then enter PLAY.
REQ-023 In PLAY, on each frame_tick, the actions SHALL be evaluated in this priority order:
        (a) ball_detect_edge[1]=0 and not (collision_detect[0]&[2]): score_L+1 -> POINT.
        (b) else ball_detect_edge[3]=0 and not (collision_detect[1]&[5]): score_R+1 -> POINT.
        (c) else if collision_detect[0]&[2]: dir_x=left; if collision_detect[1]&[5]: dir_x=right.
        (d) independently of (c): ball_detect_edge[2]=0 forces dir_y=down; ball_detect_edge[0]=0 forces dir_y=up; if both are 0, dir_y is unchanged.
REQ-024 In PLAY without a score, each ball offset SHALL move by BALL_SPEED (add for right/down, subtract for left/up) in the same tick, using the post-update direction.
REQ-025 On a score tick the ball SHALL NOT move, and point_pulse SHALL assert for exactly one cycle.
REQ-026 POINT SHALL hold for POINT_FRAMES ticks, then clear the ball offsets and do one of the following:
        - enter GAME_OVER if either score equals WIN_SCORE;
        - otherwise enter SERVE, with dir_x pointing toward the player who conceded.
REQ-027 Scores SHALL saturate at 15 and never wrap.
REQ-028 Paddles SHALL move only in SERVE and PLAY, on frame_tick, by PADDLE_SPEED:
        - up (subtract) only if the paddle's edge[1]=1;
        - down (add) only if the paddle's edge[0]=1;
        - no movement if both buttons are pressed or both are released.
REQ-029 In GAME_OVER, offsets and scores SHALL hold; start=1 SHALL behave as REQ-021.
REQ-030 In SERVE, PLAY and POINT, start SHALL be ignored.
REQ-031 The SERVE/POINT frame counter SHALL clear on every state entry.

Reset
REQ-032 rst_n=0 SHALL immediately force, regardless of clk and even mid-game:
        - game_state=IDLE;
        - all offsets, scores and counters to 0;
        - point_pulse=0, dir_x=right, dir_y=down.
REQ-033 After rst_n deasserts, the block SHALL stay in IDLE until start=1.

Verification
REQ-034 Reset, start=1 for 1 cycle, 60 frame ticks -> game_state 0->1->2; ball_off_x/y stay 0 through SERVE; first PLAY tick gives ball_off_x=2, ball_off_y=2.
REQ-035 PLAY with dir_y=down, ball_detect_edge=4'b1110 on a tick -> dir_y=up; ball_off_y decreases by 2 in the same tick.
REQ-036 PLAY with ball_detect_edge[1]=0 and collision_detect=8'h05 -> dir_x=left, no score; with collision_detect=8'h00 -> score_L=1, point_pulse high for 1 cycle, game_state=3.
REQ-037 score_R=6, left miss, then 90 ticks -> score_R=7, game_state=4, offsets 0; later start=1 -> scores 0, game_state=1.
REQ-038 btn_R_up=1 with paddle_R_detect_edge[1]=0 -> paddle_R_off_y unchanged; btn_L_up=btn_L_dn=1 -> paddle_L_off_y unchanged.
REQ-039 rst_n pulled low mid-PLAY, between clk edges -> all outputs 0 and game_state=0 before the next edge.

Source files
------------

// File: rtl/pong_game_ctrl_if.sv
// Pong controller I/O bundle: player/frame inputs toward the controller, positions/scores back.
interface pong_game_ctrl_if;
  logic        frame_tick;
  logic        start;
  logic        btn_L_up;
  logic        btn_L_dn;
  logic        btn_R_up;
  logic        btn_R_dn;
  logic [3:0]  ball_detect_edge;
  logic [3:0]  paddle_L_detect_edge;
  logic [3:0]  paddle_R_detect_edge;
  logic [7:0]  collision_detect;
  logic [31:0] ball_off_x;
  logic [31:0] ball_off_y;
  logic [31:0] paddle_L_off_y;
  logic [31:0] paddle_R_off_y;
  logic [3:0]  score_L;
  logic [3:0]  score_R;
  logic [2:0]  game_state;
  logic        point_pulse;

  modport master (
    output frame_tick, start, btn_L_up, btn_L_dn, btn_R_up, btn_R_dn,
           ball_detect_edge, paddle_L_detect_edge, paddle_R_detect_edge, collision_detect,
    input  ball_off_x, ball_off_y, paddle_L_off_y, paddle_R_off_y,
           score_L, score_R, game_state, point_pulse
  );

  modport slave (
    input  frame_tick, start, btn_L_up, btn_L_dn, btn_R_up, btn_R_dn,
           ball_detect_edge, paddle_L_detect_edge, paddle_R_detect_edge, collision_detect,
    output ball_off_x, ball_off_y, paddle_L_off_y, paddle_R_off_y,
           score_L, score_R, game_state, point_pulse
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/point sequencing, ball and paddle offsets, scoring.
module pong_game_ctrl #(
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned PADDLE_SPEED = 4,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned WIN_SCORE    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  pong_game_ctrl_if.slave  bus
);

  localparam int unsigned OFF_W      = 32;
  localparam int unsigned SCORE_W    = 4;
  localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);

  localparam logic [OFF_W-1:0]   BALL_STEP  = OFF_W'(BALL_SPEED);
  localparam logic [OFF_W-1:0]   PAD_STEP   = OFF_W'(PADDLE_SPEED);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = SCORE_W'(15);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OFF_W-1:0]   ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [OFF_W-1:0]   pad_l_q, pad_l_d, pad_r_q, pad_r_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic               dir_x_q, dir_x_d;   // 1 = right
  logic               dir_y_q, dir_y_d;   // 1 = down
  logic               point_q, point_d;

  logic hit_r_c, hit_l_c, miss_r_c, miss_l_c;
  logic unused_c;

  assign hit_r_c  = bus.collision_detect[0] & bus.collision_detect[2];
  assign hit_l_c  = bus.collision_detect[1] & bus.collision_detect[5];
  assign miss_r_c = ~bus.ball_detect_edge[1] & ~hit_r_c;
  assign miss_l_c = ~bus.ball_detect_edge[3] & ~hit_l_c;
  assign unused_c = ^{bus.collision_detect[7:6], bus.collision_detect[4:3],
                      bus.paddle_L_detect_edge[3:2], bus.paddle_R_detect_edge[3:2]};

  // Edge inputs are active-low: a paddle already at a border keeps that bit at 0.
  function automatic logic [OFF_W-1:0] paddle_next(input logic [OFF_W-1:0] off,
                                                   input logic up, input logic dn,
                                                   input logic [3:0] edge_n);
    if (up && !dn && edge_n[1])      return off - PAD_STEP;
    else if (dn && !up && edge_n[0]) return off + PAD_STEP;
    else                             return off;
  endfunction

  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    pad_l_d   = pad_l_q;
    pad_r_d   = pad_r_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;
    point_d   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          state_d   = ST_SERVE;
          cnt_d     = '0;
          ball_x_d  = '0;
          ball_y_d  = '0;
          pad_l_d   = '0;
          pad_r_d   = '0;
          score_l_d = '0;
          score_r_d = '0;
          dir_x_d   = 1'b1;
          dir_y_d   = 1'b1;
        end
      end

      ST_SERVE: begin
        if (bus.frame_tick) begin
          pad_l_d = paddle_next(pad_l_q, bus.btn_L_up, bus.btn_L_dn, bus.paddle_L_detect_edge);
          pad_r_d = paddle_next(pad_r_q, bus.btn_R_up, bus.btn_R_dn, bus.paddle_R_detect_edge);
          if (cnt_q == SERVE_LAST) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PLAY: begin
        if (bus.frame_tick) begin
          pad_l_d = paddle_next(pad_l_q, bus.btn_L_up, bus.btn_L_dn, bus.paddle_L_detect_edge);
          pad_r_d = paddle_next(pad_r_q, bus.btn_R_up, bus.btn_R_dn, bus.paddle_R_detect_edge);
          // Serve direction is set toward the conceding player at scoring time.
          if (miss_r_c) begin
            score_l_d = score_inc(score_l_q);
            dir_x_d   = 1'b1;
            point_d   = 1'b1;
            state_d   = ST_POINT;
            cnt_d     = '0;
          end else if (miss_l_c) begin
            score_r_d = score_inc(score_r_q);
            dir_x_d   = 1'b0;
            point_d   = 1'b1;
            state_d   = ST_POINT;
            cnt_d     = '0;
          end else begin
            if (hit_r_c) dir_x_d = 1'b0;
            if (hit_l_c) dir_x_d = 1'b1;
            if (!bus.ball_detect_edge[2] && bus.ball_detect_edge[0])      dir_y_d = 1'b1;
            else if (!bus.ball_detect_edge[0] && bus.ball_detect_edge[2]) dir_y_d = 1'b0;
            ball_x_d = dir_x_d ? ball_x_q + BALL_STEP : ball_x_q - BALL_STEP;
            ball_y_d = dir_y_d ? ball_y_q + BALL_STEP : ball_y_q - BALL_STEP;
          end
        end
      end

      ST_POINT: begin
        if (bus.frame_tick) begin
          if (cnt_q == POINT_LAST) begin
            ball_x_d = '0;
            ball_y_d = '0;
            cnt_d    = '0;
            state_d  = (score_l_q == WIN || score_r_q == WIN) ? ST_OVER : ST_SERVE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ball_x_q  <= '0;
      ball_y_q  <= '0;
      pad_l_q   <= '0;
      pad_r_q   <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      dir_x_q   <= 1'b1;
      dir_y_q   <= 1'b1;
      point_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ball_x_q  <= ball_x_d;
      ball_y_q  <= ball_y_d;
      pad_l_q   <= pad_l_d;
      pad_r_q   <= pad_r_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      point_q   <= point_d;
    end
  end

  assign bus.ball_off_x     = ball_x_q;
  assign bus.ball_off_y     = ball_y_q;
  assign bus.paddle_L_off_y = pad_l_q;
  assign bus.paddle_R_off_y = pad_r_q;
  assign bus.score_L        = score_l_q;
  assign bus.score_R        = score_r_q;
  assign bus.game_state     = state_q;
  assign bus.point_pulse    = point_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: PLAY vector table plus serve/point/game-over/reset sequences.
module tb_pong_game_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .BALL_SPEED(2), .PADDLE_SPEED(4), .SERVE_FRAMES(60), .POINT_FRAMES(90), .WIN_SCORE(7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] bx, by, pl, pr;
    logic [3:0]  sl, sr;
    logic [2:0]  st;
    logic        pp;
  } exp_t;

  typedef struct {
    logic [3:0]  bde;
    logic [7:0]  cd;
    logic [3:0]  btn;   // {L_up, L_dn, R_up, R_dn}
    logic [3:0]  pel, per;
    logic [31:0] bx, by, pl, pr;
    logic [3:0]  sl, sr;
    logic [2:0]  st;
    logic        pp;
  } vec_t;

  localparam logic [31:0] NEG4 = 32'hFFFF_FFFC;
  localparam logic [31:0] NEG2 = 32'hFFFF_FFFE;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  vec_t vecs[13];

  task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: queue empty, got nothing expected an entry");
      return;
    end
    e = sb_q.pop_front();
    cmp(e.name, "ball_off_x",     bus.ball_off_x,            e.bx);
    cmp(e.name, "ball_off_y",     bus.ball_off_y,            e.by);
    cmp(e.name, "paddle_L_off_y", bus.paddle_L_off_y,        e.pl);
    cmp(e.name, "paddle_R_off_y", bus.paddle_R_off_y,        e.pr);
    cmp(e.name, "score_L",        32'(bus.score_L),          32'(e.sl));
    cmp(e.name, "score_R",        32'(bus.score_R),          32'(e.sr));
    cmp(e.name, "game_state",     32'(bus.game_state),       32'(e.st));
    cmp(e.name, "point_pulse",    32'(bus.point_pulse),      32'(e.pp));
  endtask

  function automatic exp_t mk(input string n, input logic [31:0] bx, input logic [31:0] by,
                              input logic [31:0] pl, input logic [31:0] pr,
                              input logic [3:0] sl, input logic [3:0] sr,
                              input logic [2:0] st, input logic pp);
    exp_t e;
    e.name = n; e.bx = bx; e.by = by; e.pl = pl; e.pr = pr;
    e.sl = sl; e.sr = sr; e.st = st; e.pp = pp;
    return e;
  endfunction

  task automatic set_idle();
    bus.start                = 1'b0;
    bus.btn_L_up             = 1'b0;
    bus.btn_L_dn             = 1'b0;
    bus.btn_R_up             = 1'b0;
    bus.btn_R_dn             = 1'b0;
    bus.ball_detect_edge     = 4'hF;
    bus.paddle_L_detect_edge = 4'hF;
    bus.paddle_R_detect_edge = 4'hF;
    bus.collision_detect     = 8'h00;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step(input logic tk);
    bus.frame_tick = tk;
    @(posedge clk);
    #1;
    bus.frame_tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      step(1'b0);
    end
  endtask

  task automatic tick_check(input exp_t e);
    sb_q.push_back(e);
    step(1'b1);
    sb_check();
    step(1'b0);
  endtask

  initial begin
    logic [31:0] bx_e, by_e;

    // Ball starts at (2,2) moving right/down; paddles at 0.
    vecs[0]  = '{4'hF, 8'h00, 4'b0100, 4'hF, 4'hF, 32'd4,  32'd4,  32'd4, 32'd0, 4'd0, 4'd0, 3'd2, 1'b0};
    vecs[1]  = '{4'hF, 8'h00, 4'b0010, 4'hF, 4'hD, 32'd6,  32'd6,  32'd4, 32'd0, 4'd0, 4'd0, 3'd2, 1'b0};
    vecs[2]  = '{4'hF, 8'h00, 4'b1100, 4'hF, 4'hF, 32'd8,  32'd8,  32'd4, 32'd0, 4'd0, 4'd0, 3'd2, 1'b0};
    vecs[3]  = '{4'hE, 8'h00, 4'b0000, 4'hF, 4'hF, 32'd10, 32'd6,  32'd4, 32'd0, 4'd0, 4'd0, 3'd2, 1'b0};
    vecs[4]  = '{4'hA, 8'h00, 4'b0000, 4'hF, 4'hF, 32'd12, 32'd4,  32'd4, 32'd0, 4'd0, 4'd0, 3'd2, 1'b0};
    vecs[5]  = '{4'hB, 8'h00, 4'b0000, 4'hF, 4'hF, 32'd14, 32'd6,  32'd4, 32'd0, 4'd0, 4'd0, 3'd2, 1'b0};
    vecs[6]  = '{4'hD, 8'h05, 4'b0000, 4'hF, 4'hF, 32'd12, 32'd8,  32'd4, 32'd0, 4'd0, 4'd0, 3'd2, 1'b0};
    vecs[7]  = '{4'hF, 8'h00, 4'b0100, 4'hE, 4'hF, 32'd10, 32'd10, 32'd4, 32'd0, 4'd0, 4'd0, 3'd2, 1'b0};
    vecs[8]  = '{4'h7, 8'h22, 4'b0000, 4'hF, 4'hF, 32'd12, 32'd12, 32'd4, 32'd0, 4'd0, 4'd0, 3'd2, 1'b0};
    vecs[9]  = '{4'hF, 8'h00, 4'b0001, 4'hF, 4'hF, 32'd14, 32'd14, 32'd4, 32'd4, 4'd0, 4'd0, 3'd2, 1'b0};
    vecs[10] = '{4'hF, 8'h00, 4'b0010, 4'hF, 4'hF, 32'd16, 32'd16, 32'd4, 32'd0, 4'd0, 4'd0, 3'd2, 1'b0};
    vecs[11] = '{4'hF, 8'h00, 4'b0010, 4'hF, 4'hF, 32'd18, 32'd18, 32'd4, NEG4,  4'd0, 4'd0, 3'd2, 1'b0};
    vecs[12] = '{4'hD, 8'h01, 4'b0000, 4'hF, 4'hF, 32'd18, 32'd18, 32'd4, NEG4,  4'd1, 4'd0, 3'd3, 1'b1};

    bus.frame_tick = 1'b0;
    set_idle();
    rst_n = 1'b0;
    #12;
    sb_q.push_back(mk("reset", 0, 0, 0, 0, 0, 0, 3'd0, 1'b0));
    sb_check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_ticks(2);
    tick_check(mk("idle_wait", 0, 0, 0, 0, 0, 0, 3'd0, 1'b0));

    bus.start = 1'b1;
    sb_q.push_back(mk("start", 0, 0, 0, 0, 0, 0, 3'd1, 1'b0));
    step(1'b0);
    sb_check();
    bus.start = 1'b0;

    run_ticks(58);
    tick_check(mk("serve_59", 0, 0, 0, 0, 0, 0, 3'd1, 1'b0));
    tick_check(mk("serve_60", 0, 0, 0, 0, 0, 0, 3'd2, 1'b0));
    tick_check(mk("play_first", 2, 2, 0, 0, 0, 0, 3'd2, 1'b0));

    for (int i = 0; i < 13; i++) begin
      bus.ball_detect_edge     = vecs[i].bde;
      bus.collision_detect     = vecs[i].cd;
      {bus.btn_L_up, bus.btn_L_dn, bus.btn_R_up, bus.btn_R_dn} = vecs[i].btn;
      bus.paddle_L_detect_edge = vecs[i].pel;
      bus.paddle_R_detect_edge = vecs[i].per;
      sb_q.push_back(mk($sformatf("vec%0d", i), vecs[i].bx, vecs[i].by, vecs[i].pl, vecs[i].pr,
                        vecs[i].sl, vecs[i].sr, vecs[i].st, vecs[i].pp));
      step(1'b1);
      sb_check();
      step(1'b0);
      set_idle();
    end

    // Pulse must already be gone on the next cycle.
    sb_q.push_back(mk("pulse_clear", 18, 18, 4, NEG4, 1, 0, 3'd3, 1'b0));
    step(1'b0);
    sb_check();

    run_ticks(88);
    tick_check(mk("point_89", 18, 18, 4, NEG4, 1, 0, 3'd3, 1'b0));
    tick_check(mk("point_90", 0, 0, 4, NEG4, 1, 0, 3'd1, 1'b0));
    run_ticks(59);
    tick_check(mk("serve2_60", 0, 0, 4, NEG4, 1, 0, 3'd2, 1'b0));
    tick_check(mk("serve_toward_R", 2, 2, 4, NEG4, 1, 0, 3'd2, 1'b0));

    bx_e = 32'd2;
    by_e = 32'd2;
    for (int k = 1; k <= 7; k++) begin
      bus.ball_detect_edge = 4'h7;
      sb_q.push_back(mk($sformatf("miss_left%0d", k), bx_e, by_e, 4, NEG4, 1, 4'(k), 3'd3, 1'b1));
      step(1'b1);
      sb_check();
      step(1'b0);
      set_idle();
      run_ticks(89);
      if (k == 7) begin
        tick_check(mk("game_over", 0, 0, 4, NEG4, 1, 7, 3'd4, 1'b0));
      end else begin
        tick_check(mk($sformatf("point_end%0d", k), 0, 0, 4, NEG4, 1, 4'(k), 3'd1, 1'b0));
        run_ticks(59);
        tick_check(mk($sformatf("serve_end%0d", k), 0, 0, 4, NEG4, 1, 4'(k), 3'd2, 1'b0));
        tick_check(mk($sformatf("serve_toward_L%0d", k), NEG2, 2, 4, NEG4, 1, 4'(k), 3'd2, 1'b0));
        bx_e = NEG2;
        by_e = 32'd2;
      end
    end

    tick_check(mk("over_hold", 0, 0, 4, NEG4, 1, 7, 3'd4, 1'b0));

    bus.start = 1'b1;
    sb_q.push_back(mk("restart", 0, 0, 0, 0, 0, 0, 3'd1, 1'b0));
    step(1'b0);
    sb_check();
    tick_check(mk("start_ignored", 0, 0, 0, 0, 0, 0, 3'd1, 1'b0));
    bus.start = 1'b0;
    run_ticks(58);
    tick_check(mk("serve3_60", 0, 0, 0, 0, 0, 0, 3'd2, 1'b0));
    tick_check(mk("play_after_restart", 2, 2, 0, 0, 0, 0, 3'd2, 1'b0));

    // Asynchronous reset must take effect before the next clock edge.
    sb_q.push_back(mk("mid_reset", 0, 0, 0, 0, 0, 0, 3'd0, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    sb_check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_ticks(2);
    tick_check(mk("post_reset_idle", 0, 0, 0, 0, 0, 0, 3'd0, 1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
